spi_slave_multi_ch: RTL
=======================

// Module: spi_slave_multi_ch
// PURPOSE
//   Parametrised SPI slave for the FPGA controller: receives fixed-length, MSB-first frames from the
//   external SPI master and writes a DATA_W-bit payload into one of NUM_CH channel registers.
//   All four SPI modes are supported, and the slave returns ACK/NAK status on MISO.
//   Frames that are truncated, overrun or out of range are detected and discarded.
//   Sits between the SPI pins and the speed/control logic; all outputs are synchronous to clk.
// PARAMETERS
//   FRAME_W      8       bits per SPI frame (ss_n low window)
//   DATA_W       4       payload width; payload = frame[FRAME_W-1 -: DATA_W]
//   NUM_CH       4       channel registers; CH_W = max(1,$clog2(NUM_CH)); index = next CH_W bits below payload
//   CPOL         0       SCLK idle level
//   CPHA         0       0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//   ACK_CODE     8'hA5   FRAME_W-bit response sent when the previous frame committed
//   NAK_CODE     8'h5A   FRAME_W-bit response sent when the previous frame was rejected
//   SYNC_STAGES  2       flip-flop stages on sclk_in, mosi_in and ss_n_in (>=2)
//   Constraint: DATA_W+CH_W <= FRAME_W; unused low frame bits are ignored.
// PORTS
//   clk            in   1              system clock (50 MHz)
//   reset_n        in   1              asynchronous, active-low reset
//   sclk_in        in   1              SPI clock from master (asynchronous)
//   mosi_in        in   1              SPI data from master
//   ss_n_in        in   1              SPI slave select, active low
//   miso_out       out  1              SPI data to master
//   miso_oe_out    out  1              1 while a frame is active; drives the pad tristate
//   ch_data_out    out  NUM_CH*DATA_W  channel registers; channel k at [k*DATA_W +: DATA_W]
//   ch_valid_out   out  NUM_CH         one-clk pulse on the channel written
//   frame_err_out  out  1              one-clk pulse on a rejected frame
//   busy_out       out  1              1 while the FSM is not IDLE
// BEHAVIOUR
//   Reset (async assert, sync release): ch_data_out=0, ch_valid_out=0, frame_err_out=0, miso_out=0,
//     miso_oe_out=0, busy_out=0, FSM=WAIT_HI, status=ACK.
//   Inputs pass through SYNC_STAGES flip-flops, then edge detection on synced sclk and ss_n.
//   Leading edge = rise if CPOL=0, fall if CPOL=1. Sample edge = leading (CPHA=0) or trailing (CPHA=1).
//   Requirement: each SCLK half-period >= SYNC_STAGES+2 clk periods.
//   FSM:
//     WAIT_HI  synced ss_n high -> IDLE. Guarantees a frame that was in progress at reset is ignored.
//     IDLE     ss_n fall -> SHIFT; bit_cnt=0; tx_sr = status ? ACK_CODE : NAK_CODE.
//              If CPHA=0, MSB is driven on miso_out immediately.
//     SHIFT    sample edge: rx_sr={rx_sr,mosi}; bit_cnt++ (saturates at FRAME_W+1).
//              Shift edge: next tx bit on miso_out. If CPHA=1, the first leading edge drives the MSB.
//              ss_n rise -> CHECK.
//     CHECK    (1 clk) ok = bit_cnt==FRAME_W && index<NUM_CH.
//              ok: write payload to channel[index]; pulse ch_valid_out[index]; status=ACK.
//              else: no register change; pulse frame_err_out; status=NAK. -> IDLE.
//   Commit latency: ch_valid_out/frame_err_out assert SYNC_STAGES+2 clk after the ss_n_in rise.
//   The register update and the valid pulse occur on the same clk edge.
//   miso_oe_out = (state==SHIFT). miso_out returns to 0 in IDLE.
//   Response reports the PREVIOUS frame's status. The first frame after reset gets ACK_CODE.
//   Overrun (>FRAME_W sample edges) and truncation (<FRAME_W) are both rejected; status=NAK.
//   reset_n low mid-frame: immediate return to reset state; frame discarded; no pulses.
//   SCLK edges while ss_n is high are ignored.
//   ss_n fall within the same clk cycle as CHECK: CHECK completes first; the new frame starts from IDLE
//     on the next detected fall (ss_n must be seen high >= 2 clk between frames).
// TESTING
//   Defaults, mode 0, send 0x50 -> ch0=5, ch_valid_out=0001 one clk, MISO read 0xA5, others=0.
//   Send 0xA8 (payload A, ch2) -> ch2=A, ch_valid_out=0100, ch0 still 5, MISO 0xA5.
//   5-bit frame then ss_n high -> frame_err_out 1 clk, no ch_valid, regs unchanged;
//     next full frame 0x30 reads MISO 0x5A, ch0=3, and the following frame reads 0xA5.
//   9 sample edges in one frame -> frame_err_out, no write, next response 0x5A.
//   CPOL=1,CPHA=1 instance: send 0x74 -> ch1=7, MISO 0xA5. Repeat for modes 1 and 2.
//   reset_n pulsed after 4 bits, ss_n held low for 4 more bits -> no write, no pulse;
//     next clean frame 0x90 -> ch0=9, MISO 0xA5.

Source files
------------

// File: rtl/spi_slave_multi_ch.sv
// SPI slave that writes fixed-length MSB-first frames into channel registers
// and answers each frame with the ACK/NAK status of the frame before it.
module spi_slave_multi_ch #(
  parameter int FRAME_W = 8,
  parameter int DATA_W = 4,
  parameter int NUM_CH = 4,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter logic [FRAME_W-1:0] ACK_CODE = 'hA5,
  parameter logic [FRAME_W-1:0] NAK_CODE = 'h5A,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sclk_in,
  input  logic                     mosi_in,
  input  logic                     ss_n_in,
  output logic                     miso_out,
  output logic                     miso_oe_out,
  output logic [NUM_CH*DATA_W-1:0] ch_data_out,
  output logic [NUM_CH-1:0]        ch_valid_out,
  output logic                     frame_err_out,
  output logic                     busy_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int KEEP = DATA_W + CH_W;
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {
    WAIT_HI,
    IDLE,
    SHIFT,
    CHECK
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic sclk_prev_q, ss_prev_q;

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [KEEP-1:0] rx_sr_q, rx_sr_d;
  logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
  logic miso_q, miso_d;
  logic status_q, status_d;
  logic [NUM_CH*DATA_W-1:0] ch_data_q, ch_data_d;
  logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
  logic frame_err_q, frame_err_d;
  logic busy_q, busy_d;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ss_fall, ss_rise;
  logic [DATA_W-1:0] payload;
  logic [CH_W-1:0] idx;
  logic frame_ok;
  logic [FRAME_W-1:0] tx_code;

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
  assign ss_sync_d = {ss_sync_q[SYNC_STAGES-2:0], ss_n_in};

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s = ss_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign lead_edge = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge = (CPHA != 0) ? lead_edge : trail_edge;
  assign ss_fall = ~ss_s & ss_prev_q;
  assign ss_rise = ss_s & ~ss_prev_q;

  // Only the leading payload+index bits are kept; the rest of the frame is counted only.
  assign payload = rx_sr_q[KEEP-1 -: DATA_W];
  assign idx = rx_sr_q[CH_W-1:0];
  assign frame_ok = (bit_cnt_q == CNT_W'(FRAME_W))
                 && (32'(idx) < NUM_CH);
  assign tx_code = status_q ? ACK_CODE : NAK_CODE;

  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d = rx_sr_q;
    tx_sr_d = tx_sr_q;
    miso_d = miso_q;
    status_d = status_q;
    ch_data_d = ch_data_q;
    ch_valid_d = '0;
    frame_err_d = 1'b0;
    unique case (state_q)
      WAIT_HI: begin
        miso_d = 1'b0;
        if (ss_s) state_d = IDLE;
      end
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d = SHIFT;
          bit_cnt_d = '0;
          tx_sr_d = tx_code;
          if (CPHA == 0) begin
            miso_d = tx_code[FRAME_W-1];
            tx_sr_d = {tx_code[FRAME_W-2:0], 1'b0};
          end
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = CHECK;
          miso_d = 1'b0;
        end else begin
          if (sample_edge) begin
            if (bit_cnt_q < CNT_W'(KEEP))
              rx_sr_d = {rx_sr_q[KEEP-2:0], mosi_s};
            if (bit_cnt_q != CNT_W'(FRAME_W + 1))
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (shift_edge) begin
            miso_d = tx_sr_q[FRAME_W-1];
            tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok) begin
          ch_data_d[idx*DATA_W +: DATA_W] = payload;
          ch_valid_d[idx] = 1'b1;
          status_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          status_d = 1'b0;
        end
      end
      default: state_d = WAIT_HI;
    endcase
    busy_d = (state_d != IDLE);
  end

  // ss_n sync resets low so a frame already running at reset is never mistaken for a new one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_HI;
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_sync_q <= '0;
      ss_sync_q <= '0;
      sclk_prev_q <= SCLK_IDLE;
      ss_prev_q <= 1'b0;
      bit_cnt_q <= '0;
      rx_sr_q <= '0;
      tx_sr_q <= '0;
      miso_q <= 1'b0;
      status_q <= 1'b1;
      ch_data_q <= '0;
      ch_valid_q <= '0;
      frame_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q <= ss_sync_d;
      sclk_prev_q <= sclk_s;
      ss_prev_q <= ss_s;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q <= rx_sr_d;
      tx_sr_q <= tx_sr_d;
      miso_q <= miso_d;
      status_q <= status_d;
      ch_data_q <= ch_data_d;
      ch_valid_q <= ch_valid_d;
      frame_err_q <= frame_err_d;
      busy_q <= busy_d;
    end
  end

  assign miso_out = miso_q;
  assign miso_oe_out = (state_q == SHIFT);
  assign ch_data_out = ch_data_q;
  assign ch_valid_out = ch_valid_q;
  assign frame_err_out = frame_err_q;
  assign busy_out = busy_q;

endmodule
